// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: ALU operation codes and the multiply
// sequencer state encoding.
// Latency: n/a (constants and types only). Backpressure: n/a.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/thirtyTwoBitAlu.sv
// Combinational 32-bit ALU (AND/OR/ADD/SUB/SLT) used by the MIPS datapath.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a, b operands; alu_op operation code; result the selected operation.
module thirtyTwoBitAlu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      // Signed compare, zero-extended to full width.
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add multiplier controller: drives the shared ALU to form the low
// WIDTH bits of op_a*op_b. Latency: k+1 cycles from start to done, where k is
// the position of op_b's highest set bit plus one (k=0 for op_b=0).
// Backpressure: none; start is only sampled in IDLE and otherwise dropped.
// Ports: clk/rst (async active-high); start, op_a, op_b request; busy, done,
// product status/result; alu_a, alu_b, alu_op drive the ALU, alu_result returns.
module alu_mult_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_e       state_q;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] product_q, alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic             run_exit;

  // One shift-and-add iteration; only meaningful while in RUN.
  always_comb begin
    acc_d    = mplier_q[0] ? alu_result : acc_q;
    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
    // Stop early once no multiplier bits remain, or after the last bit.
    run_exit = (mplier_d == '0) || (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= ALU_AND;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          alu_op_q <= ALU_AND;
          if (start) begin
            mcand_q   <= op_a;
            mplier_q  <= op_b;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b1;
            if (op_b != '0) begin
              state_q  <= RUN;
              // ALU outputs are registered, so preload what RUN will show.
              alu_a_q  <= '0;
              alu_b_q  <= op_a;
              alu_op_q <= ALU_ADD;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (run_exit) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            product_q <= acc_d;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= ALU_AND;
          end else begin
            alu_a_q  <= acc_d;
            alu_b_q  <= mcand_d;
            alu_op_q <= ALU_ADD;
          end
        end

        DONE: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          alu_op_q <= ALU_AND;
        end

        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          alu_op_q <= ALU_AND;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
module tb_alu_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mult_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  thirtyTwoBitAlu #(.WIDTH(32)) alu (
    .a(alu_a), .b(alu_b), .alu_op(alu_op), .result(alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle E+1.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'hA5A5_A5A5;
  endtask

  // From cycle E+1, returns the cycle index (relative to E) where done is seen.
  task automatic wait_done(output int n, output logic busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  int   n;
  logic bok;

  initial begin
    // Reset state
    #2;
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_alu_op",  32'(alu_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 7 x 6: three RUN cycles, done at E+4
    launch(32'd7, 32'd6);
    wait_done(n, bok);
    chk("basic_cycles",  32'(n), 32'd4);
    chk("basic_product", product, 32'd42);
    chk("basic_busy",    32'(bok), 32'd1);
    @(negedge clk);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_hold",      product, 32'd42);

    // op_b = 0: straight to DONE
    launch(32'h1234, 32'd0);
    chk("zero_done",    32'(done), 32'd1);
    chk("zero_busy",    32'(busy), 32'd1);
    chk("zero_product", product, 32'd0);
    chk("zero_alu_op",  32'(alu_op), 32'd0);
    @(negedge clk);

    // Full length with wraparound
    launch(32'hFFFF_FFFF, 32'h8000_0001);
    wait_done(n, bok);
    chk("full_cycles",  32'(n), 32'd33);
    chk("full_product", product, 32'h7FFF_FFFF);
    chk("full_busy",    32'(bok), 32'd1);
    @(negedge clk);

    // ALU drive for 5 x 3
    chk("idle_alu_a",  alu_a, 32'd0);
    chk("idle_alu_b",  alu_b, 32'd0);
    chk("idle_alu_op", 32'(alu_op), 32'd0);
    launch(32'd5, 32'd3);
    chk("drv1_op", 32'(alu_op), 32'd2);
    chk("drv1_a",  alu_a, 32'd0);
    chk("drv1_b",  alu_b, 32'd5);
    @(negedge clk);
    chk("drv2_op", 32'(alu_op), 32'd2);
    chk("drv2_a",  alu_a, 32'd5);
    chk("drv2_b",  alu_b, 32'd10);
    @(negedge clk);
    chk("drv_done",    32'(done), 32'd1);
    chk("drv_product", product, 32'd15);
    chk("drv_done_op", 32'(alu_op), 32'd0);
    @(negedge clk);

    // start during RUN and DONE is ignored
    launch(32'd9, 32'd10);
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    wait_done(n, bok);
    chk("ign_cycles",  32'(n), 32'd5);
    chk("ign_product", product, 32'd90);
    @(negedge clk);
    chk("ign_single_done", 32'(done), 32'd0);
    chk("ign_idle_busy",   32'(busy), 32'd0);
    chk("ign_hold",        product, 32'd90);
    start = 1'b0;
    launch(32'd3, 32'd5);
    wait_done(n, bok);
    chk("next_cycles",  32'(n), 32'd4);
    chk("next_product", product, 32'd15);
    @(negedge clk);

    // Async reset in 2nd RUN cycle
    launch(32'hFFFF, 32'hFFFF);
    @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_busy",    32'(busy), 32'd0);
    chk("mid_done",    32'(done), 32'd0);
    chk("mid_product", product, 32'd0);
    chk("mid_alu_op",  32'(alu_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    launch(32'd2, 32'd3);
    wait_done(n, bok);
    chk("post_cycles",  32'(n), 32'd3);
    chk("post_product", product, 32'd6);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
